// File: rtl/instruction_encoder_pkg.sv
// Shared instruction-format definitions for the encoder and decode_instruction.
// Word layout: opcode[24:20] dest[19:17] src[16:14] pad[13:12] imm[11:0].
package instruction_encoder_pkg;

    localparam int unsigned INSTRUCTION_WIDTH = 25;
    localparam int unsigned WIDTH_OPCODE      = 5;
    localparam int unsigned REGFILE_ADDR_BITS = 3;
    localparam int unsigned IMMEDIATE_WIDTH   = 12;
    localparam int unsigned PAD_WIDTH         = 2;

    localparam int unsigned OPCODE_LSB = 20;
    localparam int unsigned DEST_LSB   = 17;
    localparam int unsigned SRC_LSB    = 14;
    localparam int unsigned PAD_LSB    = 12;
    localparam int unsigned IMM_LSB    = 0;

    localparam int unsigned OPC_MAX = 6;

    typedef enum logic [WIDTH_OPCODE-1:0] {
        OPC_NOP  = 5'd0,
        OPC_ADD  = 5'd1,
        OPC_LR   = 5'd2,
        OPC_SR   = 5'd3,
        OPC_ADDI = 5'd4,
        OPC_BEQ  = 5'd5,
        OPC_J    = 5'd6
    } opcode_e;

    typedef struct packed {
        logic [WIDTH_OPCODE-1:0]      opcode;
        logic [REGFILE_ADDR_BITS-1:0] dest;
        logic [REGFILE_ADDR_BITS-1:0] src;
        logic [PAD_WIDTH-1:0]         pad;
        logic [IMMEDIATE_WIDTH-1:0]   imm;
    } instr_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// instr_pack: combinational field packing with per-opcode masking and illegal-opcode flag.
// Masking and the opcode check exist only when ENCODER_CHECK_EN is defined.
module instr_pack
    import instruction_encoder_pkg::*;
(
    input  logic [WIDTH_OPCODE-1:0]      opcode,
    input  logic [REGFILE_ADDR_BITS-1:0] dest,
    input  logic [REGFILE_ADDR_BITS-1:0] src,
    input  logic [IMMEDIATE_WIDTH-1:0]   imm,
    output logic [INSTRUCTION_WIDTH-1:0] word_c,
    output logic                         illegal_c
);

    instr_word_t word_s;

    always_comb begin
        word_s.opcode = opcode;
        word_s.dest   = dest;
        word_s.src    = src;
        word_s.pad    = '0;
        word_s.imm    = imm;
        illegal_c     = 1'b0;
`ifdef ENCODER_CHECK_EN
        // Clear the fields each opcode does not use so the stored word is canonical
        case (opcode)
            OPC_NOP: begin
                word_s.dest = '0;
                word_s.src  = '0;
                word_s.imm  = '0;
            end
            OPC_ADD: word_s.imm = '0;
            OPC_J: begin
                word_s.dest = '0;
                word_s.src  = '0;
            end
            default: ;
        endcase
        illegal_c = (opcode > WIDTH_OPCODE'(OPC_MAX));
`else
        illegal_c = 1'b0;
`endif
        word_c = word_s;
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs instruction fields and streams them into program memory from base_addr.
// Optional ENCODER_CHECK_EN build adds field masking and illegal-opcode detection.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [PC_WIDTH-1:0]          base_addr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH_OPCODE-1:0]      in_opcode,
    input  logic [REGFILE_ADDR_BITS-1:0] in_dest,
    input  logic [REGFILE_ADDR_BITS-1:0] in_src,
    input  logic [IMMEDIATE_WIDTH-1:0]   in_imm,
    input  logic                         in_last,
    output logic                         mem_we,
    output logic [PC_WIDTH-1:0]          mem_addr,
    output logic [INSTRUCTION_WIDTH-1:0] mem_wdata,
    input  logic                         mem_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [PC_WIDTH:0]            count
);

    localparam int unsigned CNT_W = PC_WIDTH + 1;
    // Count value at which one more completed write fills the whole address space
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'({PC_WIDTH{1'b1}});

    enc_state_e                   state_q, state_d;
    logic [PC_WIDTH-1:0]          ptr_q, ptr_d;
    logic                         we_q, we_d;
    logic [INSTRUCTION_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic                         busy_q, busy_d;
    logic                         last_q, last_d;

    logic [INSTRUCTION_WIDTH-1:0] word_c;
    logic                         illegal_c;
    logic                         write_done_c;
    logic                         final_pend_c;
    logic                         accept_c;

    instr_pack u_instr_pack (
        .opcode    (in_opcode),
        .dest      (in_dest),
        .src       (in_src),
        .imm       (in_imm),
        .word_c    (word_c),
        .illegal_c (illegal_c)
    );

    // A pending write that ends the load (last word or full address space) blocks new accepts
    assign write_done_c = we_q & mem_ready;
    assign final_pend_c = we_q & (last_q | (count_q == COUNT_LAST));
    assign in_ready     = (state_q == ST_LOAD) & (~we_q | (mem_ready & ~final_pend_c));
    assign accept_c     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = err_q;
        last_d  = last_q;

        case (state_q)
            ST_LOAD: begin
                if (write_done_c) begin
                    ptr_d   = ptr_q + PC_WIDTH'(1);
                    count_d = count_q + CNT_W'(1);
                    we_d    = 1'b0;
                    if (last_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        last_d  = 1'b0;
                    end else if (count_q == COUNT_LAST) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end
                if (accept_c) begin
                    if (illegal_c) begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        we_d    = 1'b0;
                    end else begin
                        we_d    = 1'b1;
                        wdata_d = word_c;
                        last_d  = in_last;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    we_d    = 1'b0;
                    last_d  = 1'b0;
                end
            end
        endcase

        busy_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = ptr_q;
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder (PC_WIDTH=2); expectations follow ENCODER_CHECK_EN.
module tb_instruction_encoder;

    localparam int unsigned PCW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [PCW-1:0]  base_addr;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_opcode;
    logic [2:0]      in_dest;
    logic [2:0]      in_src;
    logic [11:0]     in_imm;
    logic            in_last;
    logic            mem_we;
    logic [PCW-1:0]  mem_addr;
    logic [24:0]     mem_wdata;
    logic            mem_ready;
    logic            busy;
    logic            done;
    logic            err;
    logic [PCW:0]    count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [PCW-1:0] addr;
        logic [24:0]    data;
    } wr_t;

    wr_t            exp_q[$];
    wr_t            mon_e;
    logic [PCW-1:0] next_addr = '0;
    int             ready_mode = 0;

    instruction_encoder #(.PC_WIDTH(PCW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_dest   (in_dest),
        .in_src    (in_src),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference encoding straight from the field rules
    function automatic logic [24:0] model_word(input int op, input int d, input int s, input int imm);
        int dd = d;
        int ss = s;
        int ii = imm;
`ifdef ENCODER_CHECK_EN
        if (op == 0) begin
            dd = 0; ss = 0; ii = 0;
        end else if (op == 1) begin
            ii = 0;
        end else if (op == 6) begin
            dd = 0; ss = 0;
        end
`endif
        return 25'(op * (1 << 20) + dd * (1 << 17) + ss * (1 << 14) + ii);
    endfunction

    // mem_ready driver: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       mem_ready = 1'b1;
                1:       mem_ready = ($urandom_range(0, 3) != 0);
                default: mem_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every completed write must match the scoreboard head; stalled words must hold
    initial begin
        logic           hold_prev;
        logic [PCW-1:0] hold_addr;
        logic [24:0]    hold_data;
        hold_prev = 1'b0;
        hold_addr = '0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_we", 32'(mem_we), 32'd1);
                    check("hold_addr", 32'(mem_addr), 32'(hold_addr));
                    check("hold_data", 32'(mem_wdata), 32'(hold_data));
                end
                if (mem_we && mem_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", mem_addr, mem_wdata);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                        check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
                    end
                end
                hold_prev = mem_we && !mem_ready;
                hold_addr = mem_addr;
                hold_data = mem_wdata;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the start edge
    task automatic start_load(input logic [PCW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        @(negedge clk);
        check("ready_at_start", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        start     = 1'b0;
        next_addr = b;
    endtask

    task automatic send_word(input logic [4:0] op, input logic [2:0] d, input logic [2:0] s,
                             input logic [11:0] imm, input logic last, input logic exp_wr,
                             input logic [24:0] exp_data, input int budget, output logic accepted);
        in_valid  = 1'b1;
        in_opcode = op;
        in_dest   = d;
        in_src    = s;
        in_imm    = imm;
        in_last   = last;
        accepted  = 1'b0;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1'b1;
                if (exp_wr) begin
                    exp_q.push_back('{next_addr, exp_data});
                    next_addr = next_addr + 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_checked(input string tag, input logic [4:0] op, input logic [2:0] d,
                                input logic [2:0] s, input logic [11:0] imm, input logic last,
                                input logic [24:0] exp_data);
        logic acc;
        send_word(op, d, s, imm, last, 1'b1, exp_data, 40, acc);
        check({tag, "_accepted"}, 32'(acc), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int n);
        logic seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_count"}, 32'(count), 32'(n));
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_no_lost_write"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       acc;
        logic [4:0] op;
        int         n;

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_opcode = '0;
        in_dest   = '0;
        in_src    = '0;
        in_imm    = '0;
        in_last   = 1'b0;

        #7;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four-word program with fixed expected words
        ready_mode = 0;
        start_load(2'd0);
        @(negedge clk);
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        send_checked("s1_w0", 5'd2, 3'd1, 3'd0, 12'h010, 1'b0, 25'h220010);
        send_checked("s1_w1", 5'd2, 3'd2, 3'd0, 12'h020, 1'b0, 25'h240020);
        send_checked("s1_w2", 5'd1, 3'd2, 3'd1, 12'h000, 1'b0, 25'h144000);
        send_checked("s1_w3", 5'd3, 3'd0, 3'd2, 12'h030, 1'b1, 25'h308030);
        wait_done("s1", 4);

        // Back-pressure: first word stalls three cycles while the second waits
        start_load(2'd1);
        send_checked("s2_w0", 5'd4, 3'd3, 3'd1, 12'h055, 1'b0, model_word(4, 3, 1, 12'h055));
        ready_mode = 2;
        fork
            send_checked("s2_w1", 5'd5, 3'd1, 3'd2, 12'h0aa, 1'b0, model_word(5, 1, 2, 12'h0aa));
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("s2_stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                ready_mode = 0;
            end
        join
        send_checked("s2_w2", 5'd6, 3'd7, 3'd7, 12'h3c3, 1'b0, model_word(6, 7, 7, 12'h3c3));
        send_checked("s2_w3", 5'd0, 3'd5, 3'd6, 12'h111, 1'b1, model_word(0, 5, 6, 12'h111));
        wait_done("s2", 4);

        // Masking of an ADD immediate
        start_load(2'd0);
`ifdef ENCODER_CHECK_EN
        send_checked("s3", 5'd1, 3'd2, 3'd1, 12'hfff, 1'b1, 25'h144000);
`else
        send_checked("s3", 5'd1, 3'd2, 3'd1, 12'hfff, 1'b1, 25'h144fff);
`endif
        wait_done("s3", 1);

        // Opcode 7
        start_load(2'd3);
`ifdef ENCODER_CHECK_EN
        send_word(5'd7, 3'd1, 3'd1, 12'h123, 1'b1, 1'b0, 25'h0, 40, acc);
        check("s4_accepted", 32'(acc), 32'd1);
        @(negedge clk);
        check("s4_err", 32'(err), 32'd1);
        check("s4_busy", 32'(busy), 32'd0);
        check("s4_mem_we", 32'(mem_we), 32'd0);
        check("s4_count", 32'(count), 32'd0);
        repeat (2) @(negedge clk);
        check("s4_err_sticky", 32'(err), 32'd1);
        @(posedge clk);
        #1;
        start_load(2'd0);
        @(negedge clk);
        check("s4_err_cleared", 32'(err), 32'd0);
        check("s4_busy_again", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        send_checked("s4_nop", 5'd0, 3'd5, 3'd6, 12'habc, 1'b1, model_word(0, 5, 6, 12'habc));
        wait_done("s4", 1);
`else
        send_checked("s4", 5'd7, 3'd1, 3'd1, 12'h123, 1'b1, model_word(7, 1, 1, 12'h123));
        wait_done("s4", 1);
`endif

        // Overflow: five non-last words from base 2 in a 4-word space
        start_load(2'd2);
        for (int i = 0; i < 4; i++) begin
            op = 5'($urandom_range(0, 6));
            send_checked("s5_w", op, 3'(i), 3'(i + 1), 12'(i * 16 + 5), 1'b0,
                         model_word(int'(op), i, i + 1, i * 16 + 5));
        end
        send_word(5'd2, 3'd1, 3'd1, 12'h001, 1'b0, 1'b0, 25'h0, 8, acc);
        check("s5_fifth_blocked", 32'(acc), 32'd0);
        @(negedge clk);
        check("s5_err", 32'(err), 32'd1);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_count", 32'(count), 32'd4);
        check("s5_all_written", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Randomized programs with random memory back-pressure
        ready_mode = 1;
        for (int p = 0; p < 25; p++) begin
            start_load(PCW'($urandom_range(0, 3)));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                logic [2:0]  d;
                logic [2:0]  s;
                logic [11:0] imm;
                op  = 5'($urandom_range(0, 6));
                d   = 3'($urandom_range(0, 7));
                s   = 3'($urandom_range(0, 7));
                imm = 12'($urandom_range(0, 4095));
                send_checked("rnd_w", op, d, s, imm, (i == n - 1),
                             model_word(int'(op), int'(d), int'(s), int'(imm)));
            end
            wait_done("rnd", n);
        end

        // Reset while a word is waiting on memory
        ready_mode = 2;
        start_load(2'd1);
        send_word(5'd4, 3'd2, 3'd3, 12'h7e7, 1'b0, 1'b1, model_word(4, 2, 3, 12'h7e7), 40, acc);
        check("s6_accepted", 32'(acc), 32'd1);
        @(negedge clk);
        check("s6_pending", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("s6");
        exp_q.delete();
        ready_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("s6_after");
        start_load(2'd0);
        send_checked("s6_recover", 5'd6, 3'd4, 3'd4, 12'h0f0, 1'b1, model_word(6, 4, 4, 12'h0f0));
        wait_done("s6", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
